// File: rtl/hilo_div_seq_pkg.sv
// Shared types and constants for the HI/LO sequential divide unit.
// State enum, default settle latency and divide-by-zero constants.
package hilo_div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        CAPTURE
    } state_t;

    localparam int          DIV_LAT_DEF = 4;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN     = 32'h8000_0000;

endpackage

// File: rtl/hilo_div_seq_if.sv
// Bus to the external combinational unsigned divider.
// master = HI/LO sequencer, slave = divider.
interface hilo_div_seq_if;

    logic [31:0] divu_a;
    logic [31:0] divu_b;
    logic        divu_ena;
    logic [31:0] divu_q;
    logic [31:0] divu_r;

    modport master (
        output divu_a,
        output divu_b,
        output divu_ena,
        input  divu_q,
        input  divu_r
    );

    modport slave (
        input  divu_a,
        input  divu_b,
        input  divu_ena,
        output divu_q,
        output divu_r
    );

endinterface

// File: rtl/hilo_div_seq_div_sign_fix.sv
// Signed divide pre-correction (operand magnitudes, result signs)
// and post-correction of the unsigned quotient/remainder.
module div_sign_fix (
    input  logic        sgn,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] a_mag,
    output logic [31:0] b_mag,
    output logic        neg_q,
    output logic        neg_r,
    input  logic        q_neg,
    input  logic        r_neg,
    input  logic [31:0] q,
    input  logic [31:0] r,
    output logic [31:0] q_out,
    output logic [31:0] r_out
);

    logic rt_neg;

    assign rt_neg = sgn & rt[31];
    assign neg_r  = sgn & rs[31];
    assign neg_q  = neg_r ^ rt_neg;

    // INT_MIN magnitude stays 32'h80000000, which is correct unsigned
    assign a_mag = neg_r  ? -rs : rs;
    assign b_mag = rt_neg ? -rt : rt;

    assign q_out = q_neg ? -q : q;
    assign r_out = r_neg ? -r : r;

endmodule

// File: rtl/hilo_div_seq.sv
// HI/LO register pair with a sequenced external divider.
// Signed divide is enabled by defining HILO_SIGNED_DIV_EN.
module hilo_div_seq
    import hilo_div_seq_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           div_req,
    input  logic           div_signed,
    input  logic [31:0]    rs_val,
    input  logic [31:0]    rt_val,
    input  logic           mthi,
    input  logic           mtlo,
    input  logic [31:0]    wdata,
    input  logic           mfhi,
    input  logic           mflo,
    output logic [31:0]    rdata,
    output logic           stall,
    output logic           div_by_zero,
    hilo_div_seq_if.master divu
);

    localparam logic [4:0] CNT_INIT = 5'(DIV_LAT - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, dvd;
    logic [31:0] a_q, b_q;
    logic        ena_q, dbz_q;
    logic        neg_q, neg_r;

    logic [31:0] a_pre, b_pre, q_fix, r_fix;
    logic        nq_pre, nr_pre;

`ifdef HILO_SIGNED_DIV_EN
    div_sign_fix u_sign_fix (
        .sgn   (div_signed),
        .rs    (rs_val),
        .rt    (rt_val),
        .a_mag (a_pre),
        .b_mag (b_pre),
        .neg_q (nq_pre),
        .neg_r (nr_pre),
        .q_neg (neg_q),
        .r_neg (neg_r),
        .q     (divu.divu_q),
        .r     (divu.divu_r),
        .q_out (q_fix),
        .r_out (r_fix)
    );
`else
    logic unused_sign;
    assign a_pre  = rs_val;
    assign b_pre  = rt_val;
    assign nq_pre = 1'b0;
    assign nr_pre = 1'b0;
    assign q_fix  = divu.divu_q;
    assign r_fix  = divu.divu_r;
    assign unused_sign = ^{div_signed, neg_q, neg_r};
`endif

    assign divu.divu_a   = a_q;
    assign divu.divu_b   = b_q;
    assign divu.divu_ena = ena_q;
    assign div_by_zero   = dbz_q;
    assign stall         = (state != IDLE);

    always_comb begin
        rdata = '0;
        if (mfhi)      rdata = hi;
        else if (mflo) rdata = lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            dvd   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ena_q <= 1'b0;
            dbz_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    // operands are only guaranteed valid with the request
                    if (div_req) begin
                        state <= LOAD;
                        a_q   <= a_pre;
                        b_q   <= b_pre;
                        dvd   <= rs_val;
                        neg_q <= nq_pre;
                        neg_r <= nr_pre;
                        ena_q <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                        dbz_q <= (b_q == '0);
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                CAPTURE: begin
                    if (b_q == '0) begin
                        hi <= dvd;
                        lo <= DIV_ZERO_LO;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    ena_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hilo_div_seq.md
HILO_DIV_SEQ -- requirements
Module: hilo_div_seq

Interface
REQ-001 SHALL have parameter DIV_LAT, default 4: settle cycles allowed for the combinational unsigned divider (legal range 1..31).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- div_req  in  1  one-cycle divide request
- div_signed  in  1  1 = signed divide, 0 = unsigned
- rs_val  in  32  dividend
- rt_val  in  32  divisor
- mthi, mtlo  in  1  move-to-HI / move-to-LO strobes
- wdata  in  32  data for mthi/mtlo
- mfhi, mflo  in  1  move-from-HI / move-from-LO selects
- rdata  out  32  HI/LO read data
- stall  out  1  pipeline interlock
- div_by_zero  out  1  one-cycle zero-divisor flag
- divu_a, divu_b  out  32  registered operands to the unsigned divider
- divu_ena  out  1  divider enable
- divu_q, divu_r  in  32  divider quotient and remainder

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, WAIT, CAPTURE.
REQ-004 IDLE: div_req=1 -> LOAD; all other inputs leave the state unchanged.
REQ-005 LOAD (1 cycle): SHALL register operand magnitudes into divu_a/divu_b, latch sign info, load counter=DIV_LAT-1, then go to WAIT.
REQ-006 WAIT: SHALL decrement the counter each cycle and go to CAPTURE after the cycle in which the counter reads 0 (DIV_LAT cycles in WAIT).
REQ-007 CAPTURE (1 cycle): SHALL write LO<=quotient and HI<=remainder, then return to IDLE.
REQ-008 HI/LO update latency SHALL be DIV_LAT+2 cycles after the div_req edge; new values SHALL be visible on rdata in the following cycle.
REQ-009 divu_ena SHALL be 1 in LOAD, WAIT and CAPTURE only.
REQ-010 stall SHALL equal (state != IDLE), decoded combinationally from the state register.
REQ-011 div_req, mthi and mtlo SHALL be ignored while state != IDLE.
REQ-012 In IDLE, mthi/mtlo SHALL write HI/LO on the clock edge; if div_req is also asserted, the divide result SHALL overwrite HI/LO at CAPTURE.
REQ-013 rdata SHALL be combinational:
- mfhi=1 -> HI (mfhi has priority over mflo)
- mflo=1 -> LO
- otherwise 0
REQ-014 Divisor 0: SHALL result in HI<=rs_val and LO<=32'hFFFFFFFF, with div_by_zero=1 for the CAPTURE cycle only; latency SHALL be unchanged.
REQ-015 Unsigned mode: SHALL pass rs_val/rt_val unchanged to the divider.

Reset
REQ-016 When rst_n=0, the block SHALL immediately force:
- state=IDLE, HI=0, LO=0, counter=0
- divu_a=0, divu_b=0
- stall=0, divu_ena=0, div_by_zero=0
REQ-017 Reset asserted mid-divide SHALL abort the divide with no HI/LO write.

Configuration
REQ-018 With macro HILO_SIGNED_DIV_EN defined, signed mode (div_signed=1) SHALL apply these rules:
- divide operand absolute values
- negate the quotient when the operand signs differ
- give the remainder the dividend's sign
- 32'h80000000 / 32'hFFFFFFFF SHALL yield LO=32'h80000000 and HI=0
REQ-019 Without HILO_SIGNED_DIV_EN, div_signed SHALL be ignored and all divides SHALL be unsigned.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enum
- DIV_LAT default
- constant DIV_ZERO_LO=32'hFFFFFFFF
- constant INT_MIN=32'h80000000
REQ-021 Sign pre/post correction SHALL be one sub-module, div_sign_fix, instantiated only under HILO_SIGNED_DIV_EN.
REQ-022 The unsigned divider SHALL remain external, connected through the divu_* ports.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Unsigned divide: rs=100, rt=7, DIV_LAT=4, div_req pulse -> stall high for 6 cycles; then LO=14, HI=2; mflo returns 14.
- Signed divide (macro on): rs=-7, rt=2 -> LO=-3 (32'hFFFFFFFD), HI=-1; INT_MIN/-1 -> LO=32'h80000000, HI=0.
- Zero divisor: rs=5, rt=0 -> HI=5, LO=32'hFFFFFFFF, div_by_zero pulses exactly 1 cycle.
- Move-to, then divide: mtlo wdata=32'hDEADBEEF in IDLE -> mflo reads DEADBEEF; a second div_req issued during stall is ignored (only one CAPTURE occurs).
- Simultaneous strobes in IDLE: mthi wdata=1 with div_req (10/3) -> HI=1 during stall, HI=1 and LO=3 after CAPTURE.
- Reset mid-divide: rst_n low in WAIT -> stall=0 immediately, HI=LO=0, no later CAPTURE.
